// File: rtl/sprite_pixel_renderer.sv
// sprite_pixel_renderer: 3-stage sprite ROM fetch, nibble unpack and palette lookup.
// Optional horizontal flip with `define SPRITE_MIRROR_EN (adds i_mirror).
module sprite_pixel_renderer #(
  parameter int SPR_W    = 64,
  parameter int SPR_H    = 64,
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  parameter int COORD_W  = 10,
  parameter int ROM_AW   = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_start,
  input  logic [COORD_W-1:0] i_pos_x,
  input  logic [COORD_W-1:0] i_pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic               i_mirror,
`endif
  input  logic               i_px_valid,
  input  logic [COORD_W-1:0] i_px_x,
  input  logic [COORD_W-1:0] i_px_y,
  output logic [ROM_AW-1:0]  o_rom_addr,
  input  logic [31:0]        i_rom_data,
  input  logic [23:0]        i_color_map [0:15],
  output logic               o_valid,
  output logic               o_opaque,
  output logic [23:0]        o_rgb
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int FW = FRAMES > 1 ? $clog2(FRAMES) : 1;
  localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  localparam int FRAME_WORDS = SPR_W * SPR_H / 8;
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic [FW-1:0]      anim_idx;
  logic [DW-1:0]      div_cnt;
  logic [COORD_W:0]   rel_x, rel_y;
  logic               hit;
  logic [XW-1:0]      col;
  logic [YW-1:0]      row;
  logic [ROM_AW-1:0]  addr_d;
  logic [2:0]         sel0, sel1;
  logic               hit0, hit1, val0, val1;
  logic [3:0]         idx;
  logic               opaque;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      div_cnt  <= '0;
      anim_idx <= '0;
    end else if (i_frame_start) begin
      pos_x_q <= i_pos_x;
      pos_y_q <= i_pos_y;
      div_cnt <= (div_cnt == DW'(ANIM_DIV - 1)) ? '0 : div_cnt + 1'b1;
      if (div_cnt == DW'(ANIM_DIV - 1))
        anim_idx <= (anim_idx == FW'(FRAMES - 1)) ? '0 : anim_idx + 1'b1;
    end
  assign rel_x = {1'b0, i_px_x} - {1'b0, pos_x_q};
  assign rel_y = {1'b0, i_px_y} - {1'b0, pos_y_q};
  // the >= tests stop a sprite near the far edge from wrapping onto the near edge
  assign hit = i_px_valid && i_px_x >= pos_x_q && rel_x < (COORD_W+1)'(SPR_W)
                          && i_px_y >= pos_y_q && rel_y < (COORD_W+1)'(SPR_H);
  assign row = rel_y[YW-1:0];
`ifdef SPRITE_MIRROR_EN
  logic mirror_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) mirror_q <= 1'b0;
    else if (i_frame_start) mirror_q <= i_mirror;
  assign col = mirror_q ? ~rel_x[XW-1:0] : rel_x[XW-1:0];
`else
  assign col = rel_x[XW-1:0];
`endif
  assign addr_d = ROM_AW'(anim_idx) * ROM_AW'(FRAME_WORDS)
                + ROM_AW'(row) * ROM_AW'(SPR_W / 8) + ROM_AW'(col[XW-1:3]);
  assign idx    = i_rom_data[{sel1, 2'b00} +: 4];
  assign opaque = hit1 && idx != 4'd0;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_rom_addr <= '0;
      sel0       <= '0;
      hit0       <= 1'b0;
      val0       <= 1'b0;
      sel1       <= '0;
      hit1       <= 1'b0;
      val1       <= 1'b0;
      o_valid    <= 1'b0;
      o_opaque   <= 1'b0;
      o_rgb      <= '0;
    end else begin
      o_rom_addr <= addr_d;
      sel0       <= col[2:0];
      hit0       <= hit;
      val0       <= i_px_valid;
      sel1       <= sel0;
      hit1       <= hit0;
      val1       <= val0;
      o_valid    <= val1;
      o_opaque   <= opaque;
      o_rgb      <= opaque ? i_color_map[idx] : '0;
    end
endmodule

// File: tb/tb_sprite_pixel_renderer.sv
// tb_sprite_pixel_renderer: scoreboard bench for sprite_pixel_renderer (mirror scenario under SPRITE_MIRROR_EN).
module tb_sprite_pixel_renderer;
  localparam int SPR_W = 64, SPR_H = 64, FRAMES = 4, ANIM_DIV = 2;
  logic        clk = 0, rst = 1, frame_start = 0, px_valid = 0;
  logic [9:0]  pos_x = 0, pos_y = 0, px_x = 0, px_y = 0;
  logic [10:0] rom_addr;
  logic [31:0] rom_data = 0;
  logic [23:0] color_map [0:15];
  logic        valid, opaque;
  logic [23:0] rgb;
  logic [31:0] rom [0:2047];
`ifdef SPRITE_MIRROR_EN
  logic        mirror = 0;
`endif
  typedef struct { bit v; bit hit; bit o; logic [10:0] addr; logic [23:0] rgb; } exp_t;
  typedef struct { bit v; int x; int y; bit fs; } stim_t;
  exp_t q[$];
  exp_t e;
  int   n_vec = 0, n_err = 0;
  int   m_px = 0, m_py = 0, m_anim = 0, m_div = 0;
  bit   m_mirror = 0;

  sprite_pixel_renderer #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .ANIM_DIV(ANIM_DIV),
                          .COORD_W(10), .ROM_AW(11)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start),
    .i_pos_x(pos_x), .i_pos_y(pos_y),
`ifdef SPRITE_MIRROR_EN
    .i_mirror(mirror),
`endif
    .i_px_valid(px_valid), .i_px_x(px_x), .i_px_y(px_y),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data), .i_color_map(color_map),
    .o_valid(valid), .o_opaque(opaque), .o_rgb(rgb));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic exp_t model(bit v, int x, int y);
    exp_t r;
    int rx, ry, col;
    logic [31:0] w;
    logic [3:0] nib;
    rx = x - m_px;
    ry = y - m_py;
    r.v = v; r.o = 0; r.rgb = 0; r.addr = 0;
    r.hit = v && rx >= 0 && rx < SPR_W && ry >= 0 && ry < SPR_H;
    col = m_mirror ? SPR_W - 1 - rx : rx;
    if (r.hit) begin
      r.addr = 11'(m_anim * 512 + ry * 8 + col / 8);
      w = rom[r.addr];
      nib = w[(col % 8) * 4 +: 4];
      r.o = nib != 0;
      r.rgb = r.o ? color_map[nib] : 24'h0;
    end
    return r;
  endfunction

  task automatic tick(bit v, int x, int y, bit fs);
    px_valid = v; px_x = 10'(x); px_y = 10'(y); frame_start = fs;
    q.push_back(model(v, x, y));
    if (fs) begin
      m_px = pos_x; m_py = pos_y;
`ifdef SPRITE_MIRROR_EN
      m_mirror = mirror;
`endif
      if (m_div == ANIM_DIV - 1) begin m_div = 0; m_anim = (m_anim + 1) % FRAMES; end
      else m_div++;
    end
    @(posedge clk); #1;
  endtask

  task automatic restart_model();
    exp_t z;
    z = '{v: 0, hit: 0, o: 0, addr: 0, rgb: 0};
    m_px = 0; m_py = 0; m_anim = 0; m_div = 0; m_mirror = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic test_reset();
    stim_t s[$];
    px_valid = 1; px_x = 3; px_y = 3;
    repeat (3) @(posedge clk);
    #1 n_vec++;
    if ({valid, opaque, rgb, rom_addr} !== 37'd0) begin
      n_err++; $display("FAIL reset_outputs got v%b o%b rgb %h addr %0d want all 0", valid, opaque, rgb, rom_addr);
    end
    @(negedge clk) rst = 0;
    restart_model();
    for (int i = 0; i < 4; i++) s.push_back('{1, i, 2, 0});
    s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL reset_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL reset_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
      if (i < 3) begin n_vec++; if (valid !== (i == 2)) begin n_err++; $display("FAIL reset_first_valid cycle %0d got %b want %b", i + 1, valid, i == 2); end end
    end
  endtask

  task automatic test_position();
    stim_t s[$];
    pos_x = 100; pos_y = 50;
    s.push_back('{0, 0, 0, 1}); s.push_back('{1, 100, 50, 0});
    s.push_back('{0, 0, 0, 0}); s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL pos_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL pos_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
      if (i == 1) begin n_vec++; if (rom_addr !== 11'd0) begin n_err++; $display("FAIL pos_addr0 got %0d want 0", rom_addr); end end
      if (i == 3) begin n_vec++; if ({valid, opaque, rgb} !== {2'b11, 24'haa96cf}) begin n_err++; $display("FAIL pos_rgb got v%b o%b %h want v1 o1 aa96cf", valid, opaque, rgb); end end
    end
  endtask

  task automatic test_clipping();
    stim_t s[$];
    logic [3:0] nib7;
    logic [31:0] w;
    w = rom[511]; nib7 = w[31:28];
    s.push_back('{1, 163, 113, 0}); s.push_back('{1, 164, 50, 0}); s.push_back('{1, 99, 50, 0});
    s.push_back('{1, 100, 114, 0}); s.push_back('{1, 163, 50, 0}); s.push_back('{1, 100, 49, 0});
    s.push_back('{0, 0, 0, 0}); s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL clip_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL clip_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
      if (i == 0) begin n_vec++; if (rom_addr !== 11'd511) begin n_err++; $display("FAIL clip_addr511 got %0d want 511", rom_addr); end end
      if (i == 2) begin n_vec++; if ({valid, opaque, rgb} !== {2'b11, color_map[nib7]}) begin n_err++; $display("FAIL clip_nib7 got v%b o%b %h want v1 o1 %h", valid, opaque, rgb, color_map[nib7]); end end
      if (i == 3 || i == 4) begin n_vec++; if ({valid, opaque, rgb} !== {2'b10, 24'h0}) begin n_err++; $display("FAIL clip_outside got v%b o%b %h want v1 o0 0", valid, opaque, rgb); end end
    end
  endtask

  task automatic test_transparency();
    stim_t s[$];
    s.push_back('{1, 108, 50, 0}); s.push_back('{1, 109, 50, 0});
    s.push_back('{0, 0, 0, 0}); s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL transp_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL transp_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
      if (i == 2) begin n_vec++; if ({valid, opaque, rgb} !== {2'b10, 24'h0}) begin n_err++; $display("FAIL transp_zero got v%b o%b %h want v1 o0 0", valid, opaque, rgb); end end
      if (i == 3) begin n_vec++; if ({valid, opaque, rgb} !== {2'b11, 24'haa96cf}) begin n_err++; $display("FAIL transp_neighbor got v%b o%b %h want v1 o1 aa96cf", valid, opaque, rgb); end end
    end
  endtask

  task automatic test_animation();
    stim_t s[$];
    pos_x = 100; pos_y = 50;
    repeat (2) s.push_back('{0, 0, 0, 1});
    s.push_back('{1, 100, 50, 0});
    repeat (6) s.push_back('{0, 0, 0, 1});
    s.push_back('{1, 100, 50, 0});
    s.push_back('{0, 0, 0, 0}); s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL anim_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL anim_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
      if (i == 2) begin n_vec++; if (rom_addr !== 11'd512) begin n_err++; $display("FAIL anim_step got %0d want 512", rom_addr); end end
      if (i == 9) begin n_vec++; if (rom_addr !== 11'd0) begin n_err++; $display("FAIL anim_wrap got %0d want 0", rom_addr); end end
    end
  endtask

  task automatic test_same_cycle_frame_start();
    stim_t s[$];
    pos_x = 200; pos_y = 300;
    s.push_back('{1, 100, 50, 1}); s.push_back('{1, 100, 50, 0}); s.push_back('{1, 200, 300, 0});
    s.push_back('{0, 0, 0, 0}); s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      if (i == 3) begin pos_x = 100; pos_y = 50; s[i].fs = 1; end
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL fs_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL fs_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
      if (i == 0) begin n_vec++; if (rom_addr[8:0] !== 9'd0) begin n_err++; $display("FAIL fs_old_pos got %0d want offset 0", rom_addr); end end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      bit fs;
      fs = $urandom_range(0, 39) == 0;
      if (fs) begin
        pos_x = 10'($urandom_range(0, 1023));
        pos_y = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) begin pos_x = 10'($urandom_range(60, 180)); pos_y = 10'($urandom_range(20, 120)); end
      end
      tick($urandom_range(0, 3) != 0, pos_x + $urandom_range(0, 80) - 8, pos_y + $urandom_range(0, 80) - 8, fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL b2b_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL b2b_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
    end
  endtask

  task automatic test_mid_reset();
    stim_t s[$];
    pos_x = 0; pos_y = 0;
    for (int i = 0; i < 4; i++) s.push_back('{1, i * 9, i, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL midrst_pre got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
    end
    #2 rst = 1;
    #1 n_vec++;
    if ({valid, opaque, rgb, rom_addr} !== 37'd0) begin
      n_err++; $display("FAIL midrst_flush got v%b o%b rgb %h addr %0d want all 0", valid, opaque, rgb, rom_addr);
    end
    @(negedge clk) rst = 0;
    restart_model();
    s.delete();
    for (int i = 0; i < 4; i++) s.push_back('{1, 60 + i, 63, 0});
    repeat (2) s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL midrst_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL midrst_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
    end
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror();
    stim_t s[$];
    pos_x = 100; pos_y = 50; mirror = 1;
    s.push_back('{0, 0, 0, 1}); s.push_back('{1, 100, 50, 0}); s.push_back('{1, 163, 51, 0});
    s.push_back('{0, 0, 0, 0}); s.push_back('{0, 0, 0, 0});
    foreach (s[i]) begin
      tick(s[i].v, s[i].x, s[i].y, s[i].fs);
      if (q[$].hit) begin n_vec++; if (rom_addr !== q[$].addr) begin n_err++; $display("FAIL mirror_addr got %0d want %0d", rom_addr, q[$].addr); end end
      if (q.size() >= 3) begin
        e = q.pop_front(); n_vec++;
        if ({valid, opaque, rgb} !== {e.v, e.o, e.rgb}) begin n_err++; $display("FAIL mirror_pix got v%b o%b %h want v%b o%b %h", valid, opaque, rgb, e.v, e.o, e.rgb); end
      end
      if (i == 1 && m_mirror) begin n_vec++; if (rom_addr[8:0] !== 9'd7) begin n_err++; $display("FAIL mirror_addr7 got %0d want offset 7", rom_addr); end end
    end
    mirror = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = $urandom;
    rom[0] = 32'h00000003;
    rom[1] = 32'h30303030;
    rom[511] = {4'h9, rom[511][27:0]};
    for (int i = 0; i < 16; i++) color_map[i] = 24'($urandom);
    color_map[0] = 24'h0;
    color_map[3] = 24'haa96cf;
    test_reset();
    test_position();
    test_clipping();
    test_transparency();
    test_animation();
    test_same_cycle_frame_start();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
